// File: rtl/w_grf_write_arbiter.sv
// GRF write-port driver: merges in-order W-stage writes with late (bridge load) results
// buffered in a small FIFO, and tracks registers whose late write is still outstanding.
module w_grf_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_a3,
  input  logic [31:0] pipe_wd,
  input  logic [31:0] pipe_pc,
  input  logic        issue_valid,
  input  logic [4:0]  issue_a3,
  input  logic        lt_valid,
  output logic        lt_ready,
  input  logic [4:0]  lt_a3,
  input  logic [31:0] lt_wd,
  input  logic [31:0] lt_pc,
  output logic        RegWrite,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic [31:0] PC,
  output logic [31:0] pending,
  output logic        stall_pipe,
  output logic        proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [3:0] SMAX_C = 4'(STARVE_MAX);

  logic [4:0]  mem_a3 [DEPTH];
  logic [31:0] mem_wd [DEPTH];
  logic [31:0] mem_pc [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          perr_q, perr_d;
  logic [31:0]   pend_q, pend_d;
  logic          regwrite_q, regwrite_d;
  logic [4:0]    a3_q, a3_d;
  logic [31:0]   wd_q, wd_d, pc_q, pc_d;

  logic        pipe_req, fifo_ne, enq, deq, pipe_take;
  logic [4:0]  head_a3;
  logic [31:0] head_wd, head_pc;

  assign head_a3  = mem_a3[rd_ptr_q];
  assign head_wd  = mem_wd[rd_ptr_q];
  assign head_pc  = mem_pc[rd_ptr_q];
  assign lt_ready = (count_q != FULL_C);
  assign fifo_ne  = (count_q != '0);
  assign enq      = lt_valid && lt_ready;
  assign pipe_req = pipe_we && (pipe_a3 != 5'd0);

  // While stalled the head owns the port; otherwise the head only fills idle pipe slots.
  assign deq       = fifo_ne && (stall_q || !pipe_req);
  assign pipe_take = pipe_req && !deq;

  always_comb begin
    regwrite_d = 1'b0;
    a3_d       = a3_q;
    wd_d       = wd_q;
    pc_d       = pc_q;
    if (pipe_take) begin
      regwrite_d = 1'b1;
      a3_d       = pipe_a3;
      wd_d       = pipe_wd;
      pc_d       = pipe_pc;
    end else if (deq && (head_a3 != 5'd0)) begin
      regwrite_d = 1'b1;
      a3_d       = head_a3;
      wd_d       = head_wd;
      pc_d       = head_pc;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (!fifo_ne || deq) begin
      starve_d = 4'd0;
    end else if (starve_q != SMAX_C) begin
      starve_d = starve_q + 4'd1;
    end
    if (deq) begin
      stall_d = 1'b0;
    end else if (starve_q == SMAX_C) begin
      stall_d = 1'b1;
    end
  end

  always_comb begin
    perr_d = perr_q
           | (pipe_take && pend_q[pipe_a3])
           | (deq && (head_a3 != 5'd0) && !pend_q[head_a3])
           | (lt_valid && !lt_ready);
  end

  // Set beats clear: a fresh issue to the same register is still outstanding.
  assign pend_d[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_pend
      assign pend_d[gi] = (issue_valid && (issue_a3 == 5'(gi)))
                        || (pend_q[gi] && !(deq && (head_a3 == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_a3[wr_ptr_q] <= lt_a3;
      mem_wd[wr_ptr_q] <= lt_wd;
      mem_pc[wr_ptr_q] <= lt_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= 4'd0;
      stall_q    <= 1'b0;
      perr_q     <= 1'b0;
      pend_q     <= 32'd0;
      regwrite_q <= 1'b0;
      a3_q       <= 5'd0;
      wd_q       <= 32'd0;
      pc_q       <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      perr_q     <= perr_d;
      pend_q     <= pend_d;
      regwrite_q <= regwrite_d;
      a3_q       <= a3_d;
      wd_q       <= wd_d;
      pc_q       <= pc_d;
    end
  end

  assign RegWrite   = regwrite_q;
  assign A3         = a3_q;
  assign WD         = wd_q;
  assign PC         = pc_q;
  assign pending    = pend_q;
  assign stall_pipe = stall_q;
  assign proto_err  = perr_q;
endmodule

// File: tb/tb_w_grf_write_arbiter.sv
// Directed and randomized bench for w_grf_write_arbiter against a queue-based behavioural model.
module tb_w_grf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we, issue_valid, lt_valid, lt_ready;
  logic [4:0]  pipe_a3, issue_a3, lt_a3, A3;
  logic [31:0] pipe_wd, pipe_pc, lt_wd, lt_pc, WD, PC, pending;
  logic        RegWrite, stall_pipe, proto_err;

  always #5 clk = ~clk;

  w_grf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .issue_valid(issue_valid), .issue_a3(issue_a3),
    .lt_valid(lt_valid), .lt_ready(lt_ready), .lt_a3(lt_a3), .lt_wd(lt_wd), .lt_pc(lt_pc),
    .RegWrite(RegWrite), .A3(A3), .WD(WD), .PC(PC),
    .pending(pending), .stall_pipe(stall_pipe), .proto_err(proto_err)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  // Behavioural model state: queue of buffered late results, per-register flags, starvation age.
  ent_t        mq[$];
  bit          m_pend[32];
  int          m_age;
  bit          m_stall, m_perr, m_pipe_done;
  bit          e_rw;
  logic [4:0]  e_a3;
  logic [31:0] e_wd, e_pc;
  logic [4:0]  outq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = 32'd0;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    outq.delete();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_age = 0;
    m_stall = 1'b0;
    m_perr = 1'b0;
    m_pipe_done = 1'b1;
    e_rw = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rw"}, 32'(RegWrite), 32'(e_rw));
    if (e_rw) begin
      check({tag, ".a3"}, 32'(A3), 32'(e_a3));
      check({tag, ".wd"}, WD, e_wd);
      check({tag, ".pc"}, PC, e_pc);
    end
    check({tag, ".pending"}, pending, pend_vec());
    check({tag, ".lt_ready"}, 32'(lt_ready), 32'(mq.size() < DEPTH));
    check({tag, ".stall"}, 32'(stall_pipe), 32'(m_stall));
    check({tag, ".perr"}, 32'(proto_err), 32'(m_perr));
  endtask

  // One clock with the currently driven inputs; model predicts the next-cycle outputs.
  task automatic cycle(input string tag);
    bit   ready, preq, nonempty, deq, take;
    ent_t head;
    ready    = (mq.size() < DEPTH);
    preq     = pipe_we && (pipe_a3 != 5'd0);
    nonempty = (mq.size() != 0);
    if (m_stall && nonempty) begin
      deq = 1'b1; take = 1'b0;
    end else if (preq) begin
      deq = 1'b0; take = 1'b1;
    end else begin
      deq = nonempty; take = 1'b0;
    end
    e_rw = 1'b0;
    if (take) begin
      e_rw = 1'b1; e_a3 = pipe_a3; e_wd = pipe_wd; e_pc = pipe_pc;
      if (m_pend[pipe_a3]) m_perr = 1'b1;
    end
    if (deq) begin
      head = mq.pop_front();
      if (head.a3 != 5'd0) begin
        e_rw = 1'b1; e_a3 = head.a3; e_wd = head.wd; e_pc = head.pc;
        if (!m_pend[head.a3]) m_perr = 1'b1;
        m_pend[head.a3] = 1'b0;
      end
    end
    if (lt_valid && !ready) m_perr = 1'b1;
    if (issue_valid && issue_a3 != 5'd0) m_pend[issue_a3] = 1'b1;
    if (lt_valid && ready) mq.push_back('{a3: lt_a3, wd: lt_wd, pc: lt_pc});
    // Stall follows an age that has reached the limit; any dequeue ends it.
    if (deq) m_stall = 1'b0;
    else if (m_age >= SMAX) m_stall = 1'b1;
    if (!nonempty || deq) m_age = 0;
    else if (m_age < SMAX) m_age = m_age + 1;
    m_pipe_done = !preq || take;
    @(posedge clk);
    #1;
    $display("%0t %s rw=%0d a3=%0d wd=%h pend=%h stall=%0d", $time, tag, RegWrite, A3, WD, pending, stall_pipe);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    $display("%0t %s reset", $time, tag);
    check({tag, ".rw"}, 32'(RegWrite), 32'd0);
    check({tag, ".a3"}, 32'(A3), 32'd0);
    check({tag, ".wd"}, WD, 32'd0);
    check({tag, ".pc"}, PC, 32'd0);
    check({tag, ".pending"}, pending, 32'd0);
    check({tag, ".lt_ready"}, 32'(lt_ready), 32'd1);
    check({tag, ".stall"}, 32'(stall_pipe), 32'd0);
    check({tag, ".perr"}, 32'(proto_err), 32'd0);
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_a3 = 5'd0; pipe_wd = 32'd0; pipe_pc = 32'd0;
    issue_valid = 1'b0; issue_a3 = 5'd0;
    lt_valid = 1'b0; lt_a3 = 5'd0; lt_wd = 32'd0; lt_pc = 32'd0;
  endtask

  function automatic bit reg_busy(input logic [4:0] r);
    if (m_pend[r]) return 1'b1;
    foreach (outq[i]) if (outq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    bit         saw_stall, full_seen;
    int         late_left, accepted;
    logic [4:0] r;
    bit         found;
    ent_t       dummy;

    idle();
    model_reset();
    do_reset("init");

    // Traffic in flight, then a reset with the inputs still active.
    pipe_we = 1'b1; pipe_a3 = 5'd3; pipe_wd = 32'h11; pipe_pc = 32'h100;
    issue_valid = 1'b1; issue_a3 = 5'd4;
    cycle("pre_rst0");
    issue_valid = 1'b0;
    lt_valid = 1'b1; lt_a3 = 5'd4; lt_wd = 32'h22; lt_pc = 32'h104;
    cycle("pre_rst1");
    do_reset("rst_busy");
    idle();

    // Plain pipe write, then a write to r0.
    pipe_we = 1'b1; pipe_a3 = 5'd5; pipe_wd = 32'h1234; pipe_pc = 32'h3000;
    cycle("pipe5");
    check("pipe5.lit_rw", 32'(RegWrite), 32'd1);
    check("pipe5.lit_a3", 32'(A3), 32'd5);
    check("pipe5.lit_wd", WD, 32'h1234);
    check("pipe5.lit_pc", PC, 32'h3000);
    pipe_a3 = 5'd0;
    cycle("pipe0");
    check("pipe0.lit_rw", 32'(RegWrite), 32'd0);
    idle();

    // Late write to r8: issue in cycle 0, result enqueued in cycle 3, port write in cycle 5.
    issue_valid = 1'b1; issue_a3 = 5'd8;
    cycle("late8_c0");
    idle();
    check("late8_c1.p8", 32'(pending[8]), 32'd1);
    cycle("late8_c1");
    cycle("late8_c2");
    lt_valid = 1'b1; lt_a3 = 5'd8; lt_wd = 32'hAA; lt_pc = 32'h3100;
    cycle("late8_c3");
    idle();
    check("late8_c4.p8", 32'(pending[8]), 32'd1);
    check("late8_c4.rw", 32'(RegWrite), 32'd0);
    cycle("late8_c4");
    check("late8_c5.rw", 32'(RegWrite), 32'd1);
    check("late8_c5.a3", 32'(A3), 32'd8);
    check("late8_c5.wd", WD, 32'hAA);
    check("late8_c5.p8", 32'(pending[8]), 32'd0);

    // Fill the FIFO while the pipe writes every cycle; starvation must force drains.
    for (int k = 0; k < 5; k++) begin
      issue_valid = 1'b1; issue_a3 = 5'(10 + k);
      cycle("starve_issue");
    end
    idle();
    saw_stall = 1'b0; full_seen = 1'b0; late_left = 5; accepted = 0;
    for (int k = 0; k < 80 && (late_left > 0 || mq.size() > 0); k++) begin
      if (m_pipe_done) begin
        pipe_we = 1'b1; pipe_a3 = 5'(20 + k % 8); pipe_wd = $urandom; pipe_pc = 32'h4000 + 32'(k * 4);
      end
      if (late_left > 0 && mq.size() < DEPTH) begin
        lt_valid = 1'b1; lt_a3 = 5'(15 - late_left); lt_wd = $urandom; lt_pc = 32'h5000 + 32'(late_left);
        late_left--; accepted++;
      end else begin
        lt_valid = 1'b0;
      end
      cycle("starve");
      if (stall_pipe) saw_stall = 1'b1;
      if (accepted == 4 && !full_seen) begin
        check("starve.full_ready", 32'(lt_ready), 32'd0);
        full_seen = 1'b1;
      end
    end
    idle();
    if (!m_pipe_done) begin
      pipe_we = 1'b1;
      cycle("starve_tail");
      idle();
    end
    cycle("starve_idle");
    check("starve.drained", 32'(mq.size()), 32'd0);
    check("starve.saw_stall", 32'(saw_stall), 32'd1);
    check("starve.stall_end", 32'(stall_pipe), 32'd0);
    check("starve.perr", 32'(proto_err), 32'd0);
    check("starve.pend_clear", 32'(pending[14:10]), 32'd0);

    // Re-issue r9 in the same cycle its late write dequeues.
    issue_valid = 1'b1; issue_a3 = 5'd9;
    cycle("same9_issue");
    idle();
    lt_valid = 1'b1; lt_a3 = 5'd9; lt_wd = 32'h99; lt_pc = 32'h6000;
    cycle("same9_enq");
    idle();
    issue_valid = 1'b1; issue_a3 = 5'd9;
    cycle("same9_deq");
    idle();
    check("same9.rw", 32'(RegWrite), 32'd1);
    check("same9.a3", 32'(A3), 32'd9);
    check("same9.p9", 32'(pending[9]), 32'd1);
    cycle("same9_after");
    check("same9.once", 32'(RegWrite), 32'd0);

    // Randomized traffic obeying the issue/return protocol.
    do_reset("rand_rst");
    idle();
    for (int k = 0; k < 400; k++) begin
      if (m_pipe_done) begin
        pipe_we = 1'b0; pipe_a3 = 5'd0;
        if ($urandom_range(2, 0) != 0) begin
          found = 1'b0;
          for (int t = 0; t < 8 && !found; t++) begin
            r = 5'($urandom_range(31, 0));
            if (!reg_busy(r)) found = 1'b1;
          end
          if (found) begin
            pipe_we = 1'b1; pipe_a3 = r; pipe_wd = $urandom; pipe_pc = $urandom;
          end
        end
      end
      lt_valid = 1'b0;
      if (outq.size() > 0 && mq.size() < DEPTH && $urandom_range(1, 0) == 1) begin
        lt_valid = 1'b1; lt_a3 = outq.pop_front(); lt_wd = $urandom; lt_pc = $urandom;
      end
      issue_valid = 1'b0;
      if (outq.size() < 6 && $urandom_range(3, 0) == 0) begin
        r = 5'($urandom_range(31, 1));
        if (!reg_busy(r) && r != pipe_a3) begin
          issue_valid = 1'b1; issue_a3 = r; outq.push_back(r);
        end
      end
      cycle("rand");
    end
    check("rand.perr", 32'(proto_err), 32'd0);

    // Protocol errors are sticky until reset.
    do_reset("perr_rst");
    idle();
    issue_valid = 1'b1; issue_a3 = 5'd8;
    cycle("perr_issue");
    idle();
    pipe_we = 1'b1; pipe_a3 = 5'd8; pipe_wd = 32'h5; pipe_pc = 32'h7000;
    cycle("perr_waw");
    idle();
    check("perr.waw_rw", 32'(RegWrite), 32'd1);
    check("perr.waw", 32'(proto_err), 32'd1);
    lt_valid = 1'b1; lt_a3 = 5'd17; lt_wd = 32'h17; lt_pc = 32'h7004;
    cycle("perr_enq");
    idle();
    cycle("perr_deq");
    check("perr.late_a3", 32'(A3), 32'd17);
    check("perr.sticky", 32'(proto_err), 32'd1);
    cycle("perr_hold");
    check("perr.hold", 32'(proto_err), 32'd1);
    do_reset("final_rst");
    dummy = '{a3: 5'd0, wd: 32'd0, pc: 32'd0};
    if (dummy.a3 != 5'd0) $display("unreachable");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
